// File: rtl/ips2l_uart_cmd_pkg.sv
// Shared definitions for the UART command parser: frame opcodes and FSM state encoding.
package ips2l_uart_cmd_pkg;

    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_DATA      = 3'd2,
        ST_CHK       = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/ips2l_uart_cmd_timer.sv
// Loadable down-counter with expiry flag; shared by the inter-byte and command-done timeouts.
module ips2l_uart_cmd_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/ips2l_uart_cmd_parser_32bit.sv
// UART byte stream to single register command converter ('W' addr d3..d0 / 'R' addr).
// Optional trailing XOR checksum byte when IPS2L_UART_CMD_CHECKSUM_EN is defined.
module ips2l_uart_cmd_parser_32bit
    import ips2l_uart_cmd_pkg::*;
#(
    parameter logic [15:0] BYTE_TIMEOUT = 16'd50000,
    parameter logic [15:0] DONE_TIMEOUT = 16'd1024,
    parameter int          ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           addr,
    output logic [31:0]          data,
    output logic                 we,
    output logic                 cmd_en,
    input  logic                 cmd_done,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

`ifdef IPS2L_UART_CMD_CHECKSUM_EN
    localparam state_t ST_FRAME_END = ST_CHK;
`else
    localparam state_t ST_FRAME_END = ST_ISSUE;
`endif

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_addr;
    logic [31:0]    r_data;
    logic           r_we;
    logic [1:0]     r_byte_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
    logic [7:0]     r_chk;
`endif

    logic           w_accept;
    logic           w_err;
    logic           w_tmr_load;
    logic [15:0]    w_tmr_val;
    logic           w_tmr_dec;
    logic           w_tmr_exp;

    assign rx_ready = !((r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE));
    assign w_accept = rx_valid && rx_ready;
    assign cmd_en   = (r_state == ST_ISSUE);
    assign busy     = (r_state != ST_IDLE);
    assign addr     = r_addr;
    assign data     = r_data;
    assign we       = r_we;
    assign err_cnt  = r_err_cnt;

    ips2l_uart_cmd_timer #(.W(16)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_exp)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = BYTE_TIMEOUT - 16'd1;
        w_tmr_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (is_opcode(rx_data)) begin
                        w_state_nxt = ST_ADDR;
                        w_tmr_load  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = r_we ? ST_DATA : ST_FRAME_END;
                end else if (w_tmr_exp) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_tmr_load = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = ST_FRAME_END;
                    end
                end else if (w_tmr_exp) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) begin
                    if (rx_data == r_chk) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_err       = 1'b1;
                    end
                end else if (w_tmr_exp) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
`endif
            ST_ISSUE: begin
                w_tmr_load  = 1'b1;
                w_tmr_val   = DONE_TIMEOUT - 16'd1;
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A completion in the expiry cycle wins over the timeout.
                if (cmd_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_exp) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_byte_cnt <= '0;
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
            r_chk      <= '0;
`endif
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (is_opcode(rx_data)) begin
                        r_we       <= (rx_data == OP_WR);
                        r_byte_cnt <= '0;
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
                        r_chk      <= rx_data;
`endif
                    end
                end
                ST_ADDR: begin
                    r_addr <= rx_data;
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
                    r_chk  <= r_chk ^ rx_data;
`endif
                end
                ST_DATA: begin
                    case (r_byte_cnt)
                        2'd0:    r_data[31:24] <= rx_data;
                        2'd1:    r_data[23:16] <= rx_data;
                        2'd2:    r_data[15:8]  <= rx_data;
                        default: r_data[7:0]   <= rx_data;
                    endcase
                    // Wraps to zero on the fourth byte, ready for the next frame.
                    r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IPS2L_UART_CMD_CHECKSUM_EN
                    r_chk      <= r_chk ^ rx_data;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_ONE;
        end
    end

endmodule

// File: doc/ips2l_uart_cmd_parser_32bit.md
Name: ips2l_uart_cmd_parser_32bit

Overview:
- Upstream neighbour of the 32-bit register/version control block.
- Converts the received UART byte stream into single register commands on the control block's command interface: `addr`, `data`, `we`, one-cycle `cmd_en`, then waits for `cmd_done`.
- Frame format:
  - Write: opcode 0x57 ('W'), addr, data[31:24], [23:16], [15:8], [7:0].
  - Read: opcode 0x52 ('R'), addr.
- Read data return (`fifo_data` path) is handled downstream, not here.

Parameters:
- BYTE_TIMEOUT, 16'd50000, max idle cycles between bytes of one frame before the frame is aborted.
- DONE_TIMEOUT, 16'd1024, max cycles waiting for `cmd_done` before the command is abandoned.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received UART byte
- rx_valid  in  1  `rx_data` valid; byte accepted when `rx_valid & rx_ready`
- rx_ready  out  1  parser can accept a byte
- addr  out  8  register address, held stable from `cmd_en` until `cmd_done`
- data  out  32  write data, held stable with `addr`
- we  out  1  1 = write, 0 = read; held with `addr`
- cmd_en  out  1  one-cycle command strobe
- cmd_done  in  1  command completion pulse from the control block
- busy  out  1  high from first accepted opcode until return to IDLE
- err_cnt  out  ERR_CNT_W  saturating count of dropped frames

Behaviour:
- Clock and reset: single clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values: `rx_ready`=1, `addr`=0, `data`=0, `we`=0, `cmd_en`=0, `busy`=0, `err_cnt`=0, state=IDLE, byte counter=0, timeout counter=0.
- Reset mid-frame or mid-wait: everything returns to reset values immediately. A `cmd_done` arriving after reset is ignored.
- States: IDLE, ADDR, DATA, ISSUE, WAIT_DONE.
- IDLE:
  - Accepted 0x57 → ADDR with `we`=1.
  - Accepted 0x52 → ADDR with `we`=0.
  - Any other byte: discarded, `err_cnt`+1, stay IDLE.
- ADDR:
  - Accepted byte → `addr`.
  - Then → DATA if `we`=1, else → ISSUE.
- DATA:
  - 2-bit counter, MSB first: byte k loads `data[31-8k -: 8]`.
  - 4th byte → ISSUE, counter cleared.
- Byte timeout: in ADDR/DATA, a counter increments each cycle with no accepted byte and clears on acceptance. At count == BYTE_TIMEOUT-1 → IDLE, `err_cnt`+1, partial data discarded (`data` register keeps its last value).
- ISSUE: `cmd_en`=1 for exactly one cycle → WAIT_DONE.
  - Latency: `cmd_en` asserts the cycle after the last frame byte is accepted.
- WAIT_DONE:
  - `rx_ready`=0 in ISSUE and WAIT_DONE; `rx_ready`=1 in all other states.
  - `cmd_done` → IDLE next cycle.
  - No `cmd_done` within DONE_TIMEOUT cycles → IDLE, `err_cnt`+1.
  - `cmd_done` in the same cycle as timeout expiry counts as success; no error.
- `cmd_done` outside WAIT_DONE: ignored.
- `err_cnt` saturates at all-ones and never wraps.
- Simultaneous errors in one cycle increment `err_cnt` by 1 only.
- `busy` = state != IDLE.

Optional Feature:
- Macro: `IPS2L_UART_CMD_CHECKSUM_EN`.
- Defined:
  - Each frame carries one extra trailing byte equal to the XOR of all preceding frame bytes, opcode included.
  - Extra state CHK after ADDR (read) or DATA (write).
  - Match → ISSUE.
  - Mismatch → IDLE, `err_cnt`+1, no `cmd_en`.
  - Byte timeout applies in CHK.
- Undefined: no checksum byte and no CHK state; behaviour as above.

Decomposition:
- Shared package `ips2l_uart_cmd_pkg`:
  - opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - state encoding.
  - `ips2l_uart_cmd_pkg` holds no timeout defaults, which stay as module parameters.
- Sub-module `ips2l_uart_cmd_timer`: loadable down-counter with expiry flag, instanced once and shared by the byte and done timeouts (only one is active per state).

Test Plan:
- Write: bytes 57 03 DE AD BE EF → one `cmd_en` pulse with `we`=1, `addr`=03, `data`=DEADBEEF; `rx_ready`=0 until `cmd_done`, which the bench returns 5 cycles later; then IDLE with `busy`=0.
- Read: bytes 52 FF → `cmd_en` with `we`=0, `addr`=FF; `addr` stable until `cmd_done` at +20 cycles.
- Junk and byte timeout:
  - Byte 41 in IDLE → `err_cnt`=1.
  - Then 57 05 12, followed by silence for BYTE_TIMEOUT cycles → IDLE, `err_cnt`=2, no `cmd_en`.
- Done timeout: complete read frame, `cmd_done` withheld → IDLE after DONE_TIMEOUT cycles, `err_cnt`+1. A subsequent late `cmd_done` is ignored.
- Reset in DATA (after 2 data bytes) → all outputs at reset values; a following full write frame executes normally.
- With `IPS2L_UART_CMD_CHECKSUM_EN`:
  - 52 01 53 → read issued.
  - 52 01 00 → no `cmd_en`, `err_cnt`+1.
